// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier control path.
package mult_pkg;

  localparam int N_DEFAULT = 4;
  localparam int ACC_W     = 2 * N_DEFAULT + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Step counter width; holds 0..N-1, with a 1-bit floor for tiny N.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Counts completed shift steps; last_o flags the final (N-1) step.
module mult_step_counter
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int W = cnt_w(N);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == W'(N - 1));

endmodule

// File: rtl/mult_control.sv
// Moore FSM sequencing Load/Ad/Sh commands to the ACC for one multiply.
// Handshake: St is edge-triggered in IDLE only; Busy covers the whole operation, Done pulses once.
module mult_control
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic Clk,
  input  logic rst,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  state_e state_q;
  logic   st_q;
  logic   load_q, ad_q, sh_q, busy_q, done_q;
  logic   last;
  logic   cnt_clear, cnt_inc;

  assign cnt_clear = (state_q == LOAD);
  assign cnt_inc   = (state_q == SHIFT) && !last;

  mult_step_counter #(.N(N)) u_step_counter (
    .clk_i   (Clk),
    .rst_ni  (rst),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .last_o  (last)
  );

  // Outputs are registered alongside the state so they always equal the
  // decode of state_q; M only steers the TEST branch.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      state_q <= IDLE;
      st_q    <= 1'b1;
      load_q  <= 1'b0;
      ad_q    <= 1'b0;
      sh_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q   <= St;
      load_q <= 1'b0;
      ad_q   <= 1'b0;
      sh_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (St && !st_q) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        LOAD: state_q <= TEST;
        TEST: begin
          if (M) begin
            state_q <= ADD;
            ad_q    <= 1'b1;
          end else begin
            state_q <= SHIFT;
            sh_q    <= 1'b1;
          end
        end
        ADD: begin
          state_q <= SHIFT;
          sh_q    <= 1'b1;
        end
        SHIFT: begin
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= TEST;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Load = load_q;
  assign Ad   = ad_q;
  assign Sh   = sh_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
Control unit for the shift-add multiplier. It is the initiator that drives the ACC datapath's Load/Ad/Sh command inputs.
- Samples the accumulator LSB (M = Saidas[0]) to decide add-then-shift versus shift-only for each multiplier bit.
- Start/Busy/Done handshake toward the issuing stage.
- Sits between the top-level multiplier wrapper and the ACC instance.

Parameters:
N, 4, multiplier width in bits = number of shift steps; legal range 2..16.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-low: state cleared on a Clk rising edge while rst=0.
St  input  1  start request; a new operation starts only on a 0->1 transition of St seen in IDLE.
M  input  1  current multiplier LSB from the accumulator (Saidas[0]).
Load  output  1  ACC load command, one-cycle pulse.
Ad  output  1  ACC add command, one-cycle pulse.
Sh  output  1  ACC shift-right command, one-cycle pulse.
Busy  output  1  high in every state except IDLE.
Done  output  1  completion pulse, exactly one cycle.

Behaviour:
- Moore FSM. All outputs are decoded from the state register only; M never combinationally affects outputs.
- Reset (rst=0 at an edge):
  - state=IDLE, shift count=0, St history register st_q=1.
  - Load=Ad=Sh=Done=Busy=0.
  - st_q=1 means an St held high through reset does not start an operation; St must go low, then high.
- States and outputs:
  - IDLE: all outputs 0. If St=1 and st_q=0 -> LOAD; else stay.
  - LOAD: Load=1, Busy=1; count<=0; -> TEST.
  - TEST: Ad=Sh=0, Busy=1. Samples M, which reflects the ACC value updated by the previous Load/Sh edge. M=1 -> ADD; M=0 -> SHIFT.
  - ADD: Ad=1, Busy=1; -> SHIFT.
  - SHIFT: Sh=1, Busy=1. If count==N-1 -> DONE; else count<=count+1 -> TEST.
  - DONE: Done=1, Busy=1; -> IDLE.
- st_q<=St every cycle (outside reset).
- At most one of Load/Ad/Sh is ever high in a cycle. The ACC priority logic is never exercised by this block.
- Latency from first LOAD cycle to DONE cycle inclusive: 2 + 2N + popcount(multiplier). For N=4: 10 cycles (multiplier 0000) to 14 cycles (multiplier 1111).
- Exactly N Sh pulses per operation. Ad pulses = number of 1 bits in the multiplier.
- St activity while Busy is ignored, including a new rising edge. A rising edge of St during DONE does not start a new operation: st_q is already 1 when the FSM returns to IDLE.
- Reset mid-operation: next cycle returns to IDLE with all outputs 0 and no Done pulse. A partial ACC result is left as is; the ACC has its own reset.
- Count width is CNT_W = clog2(N). Count wrap-around never occurs, because the exit is at N-1.
- M is treated as don't-care in all states except TEST.

Decomposition:
- Shared package mult_pkg:
  - state enum IDLE/LOAD/TEST/ADD/SHIFT/DONE, binary 3-bit encoding.
  - CNT_W function/localparam.
  - Default N=4, shared with the ACC width (2N+1=9).
- One sub-module, mult_step_counter (param N): clear input, increment input, last output (count==N-1). Instantiated once. The FSM itself stays in mult_control.

Test Plan:
The bench models M as an N-bit shift register: loaded from the multiplier on Load, shifted right on Sh, M = its LSB.
1. Reset then multiplier 1101: pulse St 0->1 -> Load 1 cycle, then Ad/Sh pattern Ad,Sh,Sh,Ad,Sh,Ad,Sh. Done 13 cycles after LOAD starts; 4 Sh, 3 Ad; Busy high throughout.
2. Multiplier 0000 -> no Ad ever; 4 Sh; Done on cycle 10 of the operation. Multiplier 1111 -> Ad before every Sh; Done on cycle 14.
3. St held high across Done -> FSM returns to IDLE and stays there. St low then high -> second operation starts; Load asserted the cycle after the rising edge is seen in IDLE.
4. St toggled 0->1->0->1 while Busy -> ignored: exactly one Load, one Done, N Sh per operation.
5. rst=0 asserted during the ADD state of operation 1 -> next cycle all outputs 0, Busy=0, no Done. St held high through release -> no start until St drops and rises again.
6. Every cycle of the run, checker asserts Load+Ad+Sh <= 1 and Done is never high for two consecutive cycles.
